// File: rtl/if_pkg.sv
// Shared constants and types for the parametrised instruction-fetch stage.
package if_pkg;

    localparam logic [63:0] NOP_INSTR      = 64'h0;
    localparam int          DEFAULT_DATA_W = 32;
    localparam int          BYTES_PER_WORD = DEFAULT_DATA_W / 8;
    localparam int          ALIGN_BITS     = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        REDIRECT = 2'd0,
        HOLD     = 2'd1,
        ADVANCE  = 2'd2
    } fetch_action_e;

    function automatic int word_bytes(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/imem_bytewide.sv
// Byte-array instruction memory: aligned synchronous word write, combinational little-endian word read.
module imem_bytewide
    import if_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int BYTES = word_bytes(DATA_W);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

    logic [7:0]        mem [0:DEPTH-1];
    logic [ADDR_W-1:0] wbase;

    assign wbase = waddr & ALIGN_MASK;

    // No reset: contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTES; i++) begin
                mem[ADDR_W'(wbase + ADDR_W'(i))] <= wdata[8*i +: 8];
            end
        end
    end

    // Byte addresses wrap around the top of memory.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < BYTES; i++) begin
            rdata[8*i +: 8] = mem[ADDR_W'(raddr + ADDR_W'(i))];
        end
    end

endmodule

// File: rtl/if_stage_param.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID register over a byte-wide imem.
module if_stage_param
    import if_pkg::*;
#(
    parameter int                ADDR_W   = 12,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              pc_src,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              imem_we,
    input  logic [ADDR_W-1:0] imem_waddr,
    input  logic [DATA_W-1:0] imem_wdata,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] npc,
    output logic [ADDR_W-1:0] pc_out,
    output logic              if_valid
);

    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(PC_STEP - 1);

    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_inc;
    logic [DATA_W-1:0] fetched;
    fetch_action_e     action;

    imem_bytewide #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_imem (
        .clk   (clk),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc),
        .rdata (fetched)
    );

    assign pc_inc = pc + STEP;

    // A taken branch wins over a hazard stall: the wrong-path fetch must be squashed regardless.
    always_comb begin
        action = ADVANCE;
        if (pc_src) begin
            action = REDIRECT;
        end else if (stall) begin
            action = HOLD;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= RESET_PC;
            ir       <= DATA_W'(NOP_INSTR);
            npc      <= '0;
            pc_out   <= '0;
            if_valid <= 1'b0;
        end else begin
            case (action)
                REDIRECT: begin
                    pc       <= branch_target & ALIGN_MASK;
                    ir       <= DATA_W'(NOP_INSTR);
                    if_valid <= 1'b0;
                end
                ADVANCE: begin
                    pc       <= pc_inc;
                    ir       <= fetched;
                    pc_out   <= pc;
                    npc      <= pc_inc;
                    if_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage_param.sv
// Directed self-checking bench for if_stage_param.
module tb_if_stage_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        pc_src = 1'b0;
    logic [11:0] branch_target = '0;
    logic        imem_we = 1'b0;
    logic [11:0] imem_waddr = '0;
    logic [31:0] imem_wdata = '0;
    logic [31:0] ir;
    logic [11:0] npc;
    logic [11:0] pc_out;
    logic        if_valid;

    int n_cmp = 0;
    int n_err = 0;

    if_stage_param #(
        .ADDR_W   (12),
        .DATA_W   (32),
        .RESET_PC (12'h000),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .ir            (ir),
        .npc           (npc),
        .pc_out        (pc_out),
        .if_valid      (if_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic [31:0] e_ir, input logic [11:0] e_pc,
                            input logic [11:0] e_npc, input logic e_v);
        chk({tag, ".ir"}, ir, e_ir);
        chk({tag, ".pc_out"}, {20'h0, pc_out}, {20'h0, e_pc});
        chk({tag, ".npc"}, {20'h0, npc}, {20'h0, e_npc});
        chk({tag, ".valid"}, {31'h0, if_valid}, {31'h0, e_v});
    endtask

    task automatic load(input logic [11:0] a, input logic [31:0] d);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        tick();
        imem_we    = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk_ifid("reset", 32'h0, 12'h000, 12'h000, 1'b0);
        chk("reset.pc", {20'h0, dut.pc}, 32'h0);

        // Loading happens while held in reset: writes ignore rst.
        load(12'h000, 32'hFC01F800);
        load(12'h004, 32'hFCCDF001);
        load(12'h008, 32'hFC65E802);
        load(12'h00C, 32'h00001111);
        load(12'h100, 32'h20080005);
        load(12'hFFC, 32'hAC1F0064);
        load(12'h022, 32'h12345678);   // unaligned address lands on 0x020
        chk("hold_in_reset.valid", {31'h0, if_valid}, 32'h0);

        rst = 1'b0;
        tick(); chk_ifid("seq1", 32'hFC01F800, 12'h000, 12'h004, 1'b1);
        tick(); chk_ifid("seq2", 32'hFCCDF001, 12'h004, 12'h008, 1'b1);

        stall = 1'b1;
        tick(); chk_ifid("stall1", 32'hFCCDF001, 12'h004, 12'h008, 1'b1);
        chk("stall1.pc", {20'h0, dut.pc}, 32'h008);
        tick(); chk_ifid("stall2", 32'hFCCDF001, 12'h004, 12'h008, 1'b1);
        chk("stall2.pc", {20'h0, dut.pc}, 32'h008);
        stall = 1'b0;
        tick(); chk_ifid("seq3", 32'hFC65E802, 12'h008, 12'h00C, 1'b1);

        // Redirect with simultaneous stall; target misaligned.
        pc_src = 1'b1; branch_target = 12'h103; stall = 1'b1;
        tick(); chk_ifid("bubble", 32'h0, 12'h008, 12'h00C, 1'b0);
        chk("bubble.pc", {20'h0, dut.pc}, 32'h100);
        pc_src = 1'b0; stall = 1'b0;
        tick(); chk_ifid("target", 32'h20080005, 12'h100, 12'h104, 1'b1);

        pc_src = 1'b1; branch_target = 12'hFFC;
        tick(); chk_ifid("wrap_bubble", 32'h0, 12'h100, 12'h104, 1'b0);
        pc_src = 1'b0;
        tick(); chk_ifid("wrap_top", 32'hAC1F0064, 12'hFFC, 12'h000, 1'b1);
        tick(); chk_ifid("wrap_zero", 32'hFC01F800, 12'h000, 12'h004, 1'b1);

        pc_src = 1'b1; branch_target = 12'h020;
        tick(); chk("coll_setup.pc", {20'h0, dut.pc}, 32'h020);
        pc_src = 1'b0;
        imem_we = 1'b1; imem_waddr = 12'h020; imem_wdata = 32'h8C180064;
        tick(); chk_ifid("coll_old", 32'h12345678, 12'h020, 12'h024, 1'b1);
        imem_we = 1'b0;
        pc_src = 1'b1; branch_target = 12'h020;
        tick();
        pc_src = 1'b0;
        tick(); chk_ifid("coll_new", 32'h8C180064, 12'h020, 12'h024, 1'b1);

        // Asynchronous reset pulse between edges.
        #2 rst = 1'b1;
        #1 chk_ifid("async_rst", 32'h0, 12'h000, 12'h000, 1'b0);
        chk("async_rst.pc", {20'h0, dut.pc}, 32'h0);
        #1 rst = 1'b0;
        tick(); chk_ifid("restart1", 32'hFC01F800, 12'h000, 12'h004, 1'b1);
        tick(); chk_ifid("restart2", 32'hFCCDF001, 12'h004, 12'h008, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage_param.md
Name: if_stage_param

Overview:
Parametrised instruction-fetch stage for the 5-stage MIPS pipeline. It holds the PC and a byte-addressable little-endian instruction memory, and drives the IF/ID register (ir, npc, pc_out, if_valid).
- Loading: the memory is loaded through a synchronous word write port, not through a simulation-time bus.
- New over the previous fetch stage: reset, stall, branch redirect with bubble insertion, valid flag, and parametrised widths and depth.

Parameters:
ADDR_W, 12, PC/byte-address width; the memory holds 2**ADDR_W bytes.
DATA_W, 32, instruction width; must be a multiple of 8.
RESET_PC, 0, PC value loaded on reset.
PC_STEP, 4, sequential PC increment; equals DATA_W/8.

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  asynchronous, active-high reset.
stall  in  1  hazard unit hold request; freezes PC and the IF/ID register.
pc_src  in  1  branch taken (EX/MEM PCSrc).
branch_target  in  ADDR_W  redirect address (EX/MEM ALUOut).
imem_we  in  1  instruction memory word write enable.
imem_waddr  in  ADDR_W  byte address of the word to write; low log2(PC_STEP) bits are ignored.
imem_wdata  in  DATA_W  word to write; byte 0 = bits [7:0].
ir  out  DATA_W  IF/ID instruction.
npc  out  ADDR_W  IF/ID PC+PC_STEP of the fetched instruction.
pc_out  out  ADDR_W  IF/ID address of the fetched instruction.
if_valid  out  1  IF/ID holds a real instruction.

Behaviour:
Clocking and reset
- Single clock domain.
- rst is asynchronous and active-high; all state is cleared immediately on assertion.
- Reset values: PC=RESET_PC, ir=0 (NOP), npc=0, pc_out=0, if_valid=0.
- Memory contents are not reset.

Fetch
- Read is combinational: instruction word = {mem[PC+3], mem[PC+2], mem[PC+1], mem[PC]} (generalised to PC_STEP bytes).
- Byte-address arithmetic wraps mod 2**ADDR_W.

Per rising edge, rst low, priority pc_src > stall > sequential:
- pc_src=1: PC<=branch_target with low log2(PC_STEP) bits forced to 0. IF/ID becomes a bubble (ir=0, if_valid=0; npc and pc_out hold). The wrong-path fetch is dropped. pc_src overrides stall in the same cycle.
- stall=1, pc_src=0: PC, ir, npc, pc_out and if_valid all hold.
- Otherwise: ir<=fetched word, pc_out<=PC, npc<=PC+PC_STEP, if_valid<=1, PC<=PC+PC_STEP.

Latency and wrap
- One cycle: the word at PC appears on ir after the next edge.
- PC=2**ADDR_W-PC_STEP advances to 0; npc also wraps to 0.

Memory write
- On a rising edge with imem_we=1, all PC_STEP bytes at the aligned imem_waddr are written.
- Writes are independent of stall, pc_src and rst.
- Write and fetch to the same word in the same cycle: the fetch returns the OLD word. The new word is visible from the next cycle.

Reset mid-operation
- Asserting rst between edges clears outputs at once.
- After deassertion, the first edge fetches RESET_PC.

Decomposition:
- Package if_pkg:
  - NOP_INSTR = 0
  - BYTES_PER_WORD = DATA_W/8
  - ALIGN_BITS = log2(BYTES_PER_WORD)
  - fetch_action enum (REDIRECT, HOLD, ADVANCE) used by the next-PC logic.
- One sub-module, imem_bytewide:
  - byte array with aligned word write port and combinational little-endian word read port;
  - parameters ADDR_W, DATA_W.
- if_stage_param contains the PC register, next-PC mux and the IF/ID register.

Test Plan:
- Reset and sequential fetch: load words 0xFC01F800 @0x000, 0xFCCDF001 @0x004, 0xFC65E802 @0x008; release rst.
  -> After edges 1-3: ir = those words in order; pc_out = 0x000/0x004/0x008; npc = 0x004/0x008/0x00C; if_valid=1.
- Stall: assert stall for 2 cycles after the fetch at 0x004.
  -> ir stays 0xFCCDF001 and PC stays 0x008 for both cycles. The next edge after release fetches 0x008.
- Branch redirect: pc_src=1, branch_target=0x103 while PC=0x00C, with stall=1 in the same cycle.
  -> Next edge: if_valid=0, ir=0, PC=0x100. The following edge: ir=mem word @0x100, pc_out=0x100.
- Wrap-around: branch to 0xFFC holding 0xAC1F0064.
  -> ir=0xAC1F0064, npc=0x000. The next fetch has pc_out=0x000.
- Write/read collision: PC=0x020 and imem_we=1, imem_waddr=0x020, imem_wdata=0x8C180064 in the same cycle.
  -> ir = old word. After a branch back to 0x020, ir=0x8C180064.
- Async reset mid-run: pulse rst between edges while if_valid=1.
  -> ir=0 and if_valid=0 before the next edge. Fetch restarts at RESET_PC; memory contents are intact.
